hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of MEM_WAIT cycles before a memory timeout error.
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1, asynchronous active-high reset); the block has one clock, and reset is asynchronous and active-high.
REQ-003 SHALL have input id_rs1, id_rs2 (5 each): source registers of the instruction in ID.
REQ-004 SHALL have input ex_rs1, ex_rs2, ex_rd (5 each), ex_mem_read (1) and ex_redirect (1): the ID/EX register outputs, where ex_redirect means a taken branch or a jump in EX.
REQ-005 SHALL have input mem_rd (5), mem_reg_write (1), dmem_req (1) and dmem_ack (1): MEM stage destination, write enable, and data-memory handshake.
REQ-006 SHALL have input wb_rd (5) and wb_reg_write (1): WB stage destination and write enable.
REQ-007 SHALL have outputs stall_pc, stall_if_id, stall_id_ex and stall_ex_mem (1 each): hold the PC or the named pipeline register.
REQ-008 SHALL have outputs flush_if_id, flush_id_ex and flush_mem_wb (1 each): load a bubble into the named pipeline register.
REQ-009 SHALL have outputs fwd_a and fwd_b (2 each): ALU operand forwarding select, where 00 means register file, 01 means WB and 10 means MEM.
REQ-010 SHALL have outputs err (1, sticky memory-timeout flag) and stall_cycles (16, saturating count of stalled cycles).

Function
REQ-011 fwd_a SHALL be 10 when mem_reg_write, mem_rd!=0 and mem_rd==ex_rs1; else 01 when wb_reg_write, wb_rd!=0 and wb_rd==ex_rs1; else 00. MEM SHALL take priority over WB. fwd_b SHALL follow the same rule using ex_rs2. Both SHALL be combinational in every state.
REQ-012 lu (load-use) SHALL equal ex_mem_read AND ex_rd!=0 AND (ex_rd==id_rs1 OR ex_rd==id_rs2).
REQ-013 The FSM SHALL have states RUN, MEM_WAIT and FLUSH, held in a registered state variable; all stall/flush outputs SHALL be combinational from the state and the inputs.
REQ-014 In RUN with dmem_req=1 and dmem_ack=0, the block SHALL assert all four stalls and flush_mem_wb, and the next state SHALL be MEM_WAIT. This case SHALL have the highest priority, and no other flush SHALL be asserted.
REQ-015 In RUN, otherwise if ex_redirect=1, the block SHALL assert flush_if_id and flush_id_ex, and the next state SHALL be FLUSH; redirect SHALL override lu.
REQ-016 In RUN, otherwise if lu=1, the block SHALL assert stall_pc, stall_if_id and flush_id_ex for exactly that cycle, and SHALL stay in RUN.
REQ-017 In RUN with none of the above conditions, all stall and flush outputs SHALL be 0.
REQ-018 In FLUSH, the block SHALL assert flush_if_id only, to cover the 1-cycle registered instruction-memory latency, and the next state SHALL be RUN unconditionally.
REQ-019 In MEM_WAIT, the block SHALL assert all four stalls and flush_mem_wb, and SHALL ignore ex_redirect and lu. Because EX is held, these are re-evaluated after RUN resumes.
REQ-020 In MEM_WAIT, on dmem_ack=1 all outputs SHALL behave as in RUN-idle (all 0) for that cycle, and the next state SHALL be RUN.
REQ-021 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ack.
REQ-022 When the wait counter reaches TIMEOUT, err SHALL set and stay set until reset, and the next state SHALL be RUN. If ack and timeout occur in the same cycle, ack SHALL win and err SHALL stay unchanged.
REQ-023 stall_cycles SHALL increment on every cycle in which stall_pc=1, and SHALL saturate at 0xFFFF.
REQ-024 A 1-cycle ack (dmem_req=1 and dmem_ack=1 in the same RUN cycle) SHALL cause no stall.

Reset
REQ-025 While rst=1, asynchronously: state SHALL be RUN, the wait counter SHALL be 0, err SHALL be 0 and stall_cycles SHALL be 0.
REQ-026 Reset asserted in MEM_WAIT or FLUSH SHALL abort to RUN immediately, with no residual stall.
REQ-027 Combinational outputs during reset SHALL follow the RUN rules.

Verification
REQ-028 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> one cycle of stall_pc, stall_if_id and flush_id_ex; then, with ex_mem_read=0, all outputs are 0; stall_cycles=1.
REQ-029 Forwarding priority: mem_rd=wb_rd=ex_rs1=7, both write enables=1 -> fwd_a=10. With mem_rd=0 and ex_rs1=0 -> fwd_a=00.
REQ-030 Redirect with lu in the same cycle: flush_if_id and flush_id_ex with no stall, then one FLUSH cycle with flush_if_id only, then RUN.
REQ-031 Memory wait: dmem_req=1 with ack after 3 cycles -> all four stalls asserted for 3 cycles, release on the ack cycle, stall_cycles=3.
REQ-032 Timeout: TIMEOUT=4 and no ack -> err=1 after 4 MEM_WAIT cycles and state returns to RUN; err stays 1 until rst; a subsequent ack has no effect on err.
REQ-033 Reset mid-wait: rst pulse in MEM_WAIT cycle 2 -> stalls deassert asynchronously, stall_cycles=0, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control with data-memory wait FSM,
// sticky timeout error and saturating stall counter.
module hazard_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  ex_rs1,
   input  logic [4:0]  ex_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_redirect,
   input  logic [4:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic        dmem_req,
   input  logic        dmem_ack,
   input  logic [4:0]  wb_rd,
   input  logic        wb_reg_write,
   output logic        stall_pc,
   output logic        stall_if_id,
   output logic        stall_id_ex,
   output logic        stall_ex_mem,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        flush_mem_wb,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        err,
   output logic [15:0] stall_cycles
);
   typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
   state_t state, next;
   logic [7:0] wcnt;
   logic lu, miss, tmo;
   assign lu = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
   assign miss = dmem_req && !dmem_ack;
   // counter reaches TIMEOUT on the increment happening this cycle
   assign tmo = wcnt == 8'(TIMEOUT - 1);
   assign fwd_a = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
                  (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b01 : 2'b00;
   assign fwd_b = (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
                  (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b01 : 2'b00;
   always_comb begin
      next = state;
      {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b0;
      {flush_if_id, flush_id_ex, flush_mem_wb} = 3'b0;
      case (state)
         RUN:
            if (miss) begin
               {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_mem_wb} = 5'b11111;
               next = MEM_WAIT;
            end else if (ex_redirect) begin
               {flush_if_id, flush_id_ex} = 2'b11;
               next = FLUSH;
            end else if (lu) begin
               {stall_pc, stall_if_id, flush_id_ex} = 3'b111;
            end
         MEM_WAIT:
            if (dmem_ack) next = RUN;
            else begin
               {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_mem_wb} = 5'b11111;
               next = tmo ? RUN : MEM_WAIT;
            end
         FLUSH: begin
            flush_if_id = 1'b1;
            next = RUN;
         end
         default: next = RUN;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         wcnt <= 8'd0;
         err <= 1'b0;
         stall_cycles <= 16'd0;
      end else begin
         state <= next;
         wcnt <= (state != MEM_WAIT) ? 8'd0 : dmem_ack ? wcnt : wcnt + 8'd1;
         err <= err | (state == MEM_WAIT && !dmem_ack && tmo);
         stall_cycles <= stall_cycles + 16'(stall_pc && stall_cycles != 16'hFFFF);
      end
   end
endmodule
